// File: rtl/sram_mem_ctrl_pkg.sv
// Purpose: shared constants, FSM state encoding and half-word address helper for sram_mem_ctrl.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_mem_ctrl_pkg;

    localparam int WORD_WIDTH      = 32;
    localparam int SRAM_DATA_WIDTH = 16;
    localparam int SRAM_ADDR_WIDTH = 18;
    localparam logic [WORD_WIDTH-1:0] BASE_ADDR = 32'd1024;

    // Word index bits that survive truncation to the SRAM half-word address
    localparam int IDX_WIDTH = SRAM_ADDR_WIDTH - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Half-word address of the low (hi=0) or high (hi=1) half of a word
    function automatic logic [SRAM_ADDR_WIDTH-1:0] hw_addr(input logic [IDX_WIDTH-1:0] idx,
                                                           input logic                 hi);
        return {idx, hi};
    endfunction

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Purpose: pipeline-side load/store request and response bundle of the memory stage.
// Latency: n/a (wires only).
// Backpressure: ready=0 freezes the requester, which holds its outputs stable.
interface sram_mem_ctrl_if;
    import sram_mem_ctrl_pkg::*;

    logic                  mem_read;
    logic                  mem_write;
    logic [WORD_WIDTH-1:0] address;
    logic [WORD_WIDTH-1:0] write_data;
    logic [WORD_WIDTH-1:0] read_data;
    logic                  ready;

    // Execute stage side
    modport master (
        output mem_read, mem_write, address, write_data,
        input  read_data, ready
    );

    // Memory controller side
    modport slave (
        input  mem_read, mem_write, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_mem_ctrl_phase_timer.sv
// Purpose: wait-state counter for one SRAM half-access phase, terminal flag at WAIT_CYCLES.
// Latency: term asserts WAIT_CYCLES cycles after the last clear.
// Backpressure: none; the FSM drives clr/en every cycle.
module sram_phase_timer #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(WAIT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority over count so a phase transition always restarts at zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == TERM_CNT);

endmodule

// File: rtl/sram_mem_ctrl.sv
// Purpose: memory-stage load/store responder, each word done as two half-word async SRAM accesses.
// Latency: request seen at cycle 0 completes in DONE at cycle 2*(WAIT_CYCLES+1)+1.
// Backpressure: ready=0 from the request cycle until DONE; inputs ignored outside IDLE.
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    sram_mem_ctrl_if.slave             pipe,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
    output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
    output logic                       sram_dq_oe,
    output logic                       sram_we_n
);

    localparam int HALF = SRAM_DATA_WIDTH;

    // The operation (read/write) is carried by the state itself, so only
    // the word index and store data need latching.
    state_t                      state_q,  state_d;
    logic [IDX_WIDTH-1:0]        idx_q,    idx_d;
    logic [WORD_WIDTH-1:0]       data_q,   data_d;
    logic [SRAM_ADDR_WIDTH-1:0]  addr_q,   addr_d;
    logic [WORD_WIDTH-1:0]       rdata_q,  rdata_d;

    logic                  req;
    logic                  in_phase;
    logic                  tmr_clr;
    logic                  tmr_en;
    logic                  tmr_term;
    logic [WORD_WIDTH-1:0] off;
    logic                  unused_off;

    // Byte offset from the SRAM window base; wraps modulo 2^WORD_WIDTH.
    // Byte-within-word bits and index bits above the SRAM range are dropped.
    assign off        = pipe.address - BASE_ADDR;
    assign unused_off = ^{off[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1], off[1:0]};

    assign req      = pipe.mem_read | pipe.mem_write;
    assign in_phase = (state_q == RD_LO) || (state_q == RD_HI) ||
                      (state_q == WR_LO) || (state_q == WR_HI);

    // Counter runs only inside a half-access phase and restarts on each transition
    assign tmr_clr = !in_phase || tmr_term;
    assign tmr_en  = in_phase && !tmr_term;

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .term (tmr_term)
    );

    // Next-state, latching and read-data capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    // Write wins when both request lines are high
                    state_d = pipe.mem_write ? WR_LO : RD_LO;
                    idx_d   = off[SRAM_ADDR_WIDTH:2];
                    data_d  = pipe.write_data;
                    addr_d  = hw_addr(off[SRAM_ADDR_WIDTH:2], 1'b0);
                end
            end
            RD_LO: begin
                if (tmr_term) begin
                    rdata_d[HALF-1:0] = sram_dq_in;
                    state_d           = RD_HI;
                    addr_d            = hw_addr(idx_q, 1'b1);
                end
            end
            RD_HI: begin
                if (tmr_term) begin
                    rdata_d[WORD_WIDTH-1:HALF] = sram_dq_in;
                    state_d                    = DONE;
                end
            end
            WR_LO: begin
                if (tmr_term) begin
                    state_d = WR_HI;
                    addr_d  = hw_addr(idx_q, 1'b1);
                end
            end
            WR_HI: begin
                if (tmr_term) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    // SRAM strobes decoded from state so reset releases we_n without a clock
    always_comb begin
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state_q)
            WR_LO: begin
                sram_dq_out = data_q[HALF-1:0];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
            end
            WR_HI: begin
                sram_dq_out = data_q[WORD_WIDTH-1:HALF];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
            end
            default: begin
                sram_dq_out = '0;
            end
        endcase
    end

    assign sram_addr      = addr_q;
    assign pipe.read_data = rdata_q;
    assign pipe.ready     = ((state_q == IDLE) && !req) || (state_q == DONE);

endmodule

// File: tb/tb_sram_mem_ctrl.sv
module tb_sram_mem_ctrl;

    logic clk;
    logic rst;

    sram_mem_ctrl_if pif0 ();
    sram_mem_ctrl_if pif1 ();

    // Per-DUT stimulus (DUT0: WAIT_CYCLES=1, DUT1: WAIT_CYCLES=0)
    logic        mr [2];
    logic        mw [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];

    logic [17:0] sa   [2];
    logic [15:0] dqi  [2];
    logic [15:0] dqo  [2];
    logic        oe   [2];
    logic        we_n [2];
    logic        rdy  [2];
    logic [31:0] rdat [2];

    // External SRAM contents seen by each DUT
    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];

    assign pif0.mem_read   = mr[0];
    assign pif0.mem_write  = mw[0];
    assign pif0.address    = ad[0];
    assign pif0.write_data = wd[0];
    assign pif1.mem_read   = mr[1];
    assign pif1.mem_write  = mw[1];
    assign pif1.address    = ad[1];
    assign pif1.write_data = wd[1];
    assign rdy[0]  = pif0.ready;
    assign rdy[1]  = pif1.ready;
    assign rdat[0] = pif0.read_data;
    assign rdat[1] = pif1.read_data;
    assign dqi[0]  = mem0[sa[0][7:0]];
    assign dqi[1]  = mem1[sa[1][7:0]];

    sram_mem_ctrl #(.WAIT_CYCLES(1)) u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .pipe        (pif0),
        .sram_addr   (sa[0]),
        .sram_dq_in  (dqi[0]),
        .sram_dq_out (dqo[0]),
        .sram_dq_oe  (oe[0]),
        .sram_we_n   (we_n[0])
    );

    sram_mem_ctrl #(.WAIT_CYCLES(0)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .pipe        (pif1),
        .sram_addr   (sa[1]),
        .sram_dq_in  (dqi[1]),
        .sram_dq_out (dqo[1]),
        .sram_dq_oe  (oe[1]),
        .sram_we_n   (we_n[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM write model
    always @(posedge clk) begin
        if (we_n[0] == 1'b0) mem0[sa[0][7:0]] <= dqo[0];
        if (we_n[1] == 1'b0) mem1[sa[1][7:0]] <= dqo[1];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, d, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int          wv [2] = '{1, 0};
    int          t  [2];             // cycles since acceptance, 0 = idle
    logic        m_wr [2];
    logic [17:0] m_lo [2];
    logic [31:0] m_wd [2];
    logic [31:0] m_rd [2];
    logic [17:0] m_last [2];
    logic [15:0] sh [2][256];

    always @(negedge clk) begin : model_cmp
        int ph;
        int h;
        logic [31:0] off;
        for (int d = 0; d < 2; d++) begin
            ph = wv[d] + 1;
            if (rst == 1'b0) begin
                chk("rst_ready", d, {31'd0, rdy[d]}, {31'd0, !(mr[d] | mw[d])});
                chk("rst_we_n", d, {31'd0, we_n[d]}, 32'd1);
                chk("rst_oe", d, {31'd0, oe[d]}, 32'd0);
                chk("rst_addr", d, {14'd0, sa[d]}, 32'd0);
                chk("rst_rdata", d, rdat[d], 32'd0);
                t[d] = 0; m_rd[d] = 32'd0; m_last[d] = 18'd0;
            end else if (t[d] == 0) begin
                chk("idle_ready", d, {31'd0, rdy[d]}, {31'd0, !(mr[d] | mw[d])});
                chk("idle_we_n", d, {31'd0, we_n[d]}, 32'd1);
                chk("idle_oe", d, {31'd0, oe[d]}, 32'd0);
                chk("idle_addr", d, {14'd0, sa[d]}, {14'd0, m_last[d]});
                chk("idle_rdata", d, rdat[d], m_rd[d]);
                if (mr[d] | mw[d]) begin
                    off     = ad[d] - 32'd1024;
                    m_lo[d] = 18'((off / 4) * 2);
                    m_wr[d] = mw[d];
                    m_wd[d] = wd[d];
                    if (mw[d]) begin
                        sh[d][m_lo[d][7:0]]         = wd[d][15:0];
                        sh[d][m_lo[d][7:0] + 8'd1]  = wd[d][31:16];
                    end else begin
                        m_rd[d] = {sh[d][m_lo[d][7:0] + 8'd1], sh[d][m_lo[d][7:0]]};
                    end
                    t[d] = 1;
                end
            end else if (t[d] <= 2 * ph) begin
                h = (t[d] - 1) / ph;
                m_last[d] = m_lo[d] + 18'(h);
                chk("busy_ready", d, {31'd0, rdy[d]}, 32'd0);
                chk("busy_addr", d, {14'd0, sa[d]}, {14'd0, m_last[d]});
                if (m_wr[d]) begin
                    chk("wr_we_n", d, {31'd0, we_n[d]}, 32'd0);
                    chk("wr_oe", d, {31'd0, oe[d]}, 32'd1);
                    chk("wr_dq", d, {16'd0, dqo[d]}, {16'd0, (h == 0) ? m_wd[d][15:0] : m_wd[d][31:16]});
                end else begin
                    chk("rd_we_n", d, {31'd0, we_n[d]}, 32'd1);
                    chk("rd_oe", d, {31'd0, oe[d]}, 32'd0);
                end
                t[d] = t[d] + 1;
            end else begin
                chk("done_ready", d, {31'd0, rdy[d]}, 32'd1);
                chk("done_we_n", d, {31'd0, we_n[d]}, 32'd1);
                chk("done_rdata", d, rdat[d], m_rd[d]);
                t[d] = 0;
            end
        end
    end

    // Issue one access, wait for DONE (bounded), then drop the request
    task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] dat, output int done_cyc);
        mr[d] = r; mw[d] = w; ad[d] = a; wd[d] = dat;
        done_cyc = -1;
        for (int c = 0; c < 20 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (rdy[d]) done_cyc = c;
        end
        @(posedge clk); #1;
        mr[d] = 1'b0; mw[d] = 1'b0;
        if (done_cyc < 0) chk("access_timeout", d, 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int dc;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mr[d] = 1'b0; mw[d] = 1'b0; ad[d] = 32'd0; wd[d] = 32'd0;
            t[d] = 0; m_rd[d] = 32'd0; m_last[d] = 18'd0;
            m_wr[d] = 1'b0; m_lo[d] = 18'd0; m_wd[d] = 32'd0;
            for (int i = 0; i < 256; i++) sh[d][i] = 16'd0;
        end
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 16'd0;
            mem1[i] = 16'd0;
        end
        mem1[0] = 16'h5678; mem1[1] = 16'h1234;
        sh[1][0] = 16'h5678; sh[1][1] = 16'h1234;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Idle: no request for 10 cycles
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle10_ready", 0, {31'd0, rdy[0]}, 32'd1);
        end
        @(posedge clk); #1;

        // Store 0xDEADBEEF at 1032, cycle-by-cycle literal expectations
        mw[0] = 1'b1; ad[0] = 32'd1032; wd[0] = 32'hDEADBEEF;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            chk("st_ready", 0, {31'd0, rdy[0]}, (c == 5) ? 32'd1 : 32'd0);
            if (c >= 1 && c <= 4) begin
                chk("st_addr", 0, {14'd0, sa[0]}, (c <= 2) ? 32'd4 : 32'd5);
                chk("st_dq", 0, {16'd0, dqo[0]}, (c <= 2) ? 32'h0000BEEF : 32'h0000DEAD);
                chk("st_we_n", 0, {31'd0, we_n[0]}, 32'd0);
                chk("st_oe", 0, {31'd0, oe[0]}, 32'd1);
            end
        end
        @(posedge clk); #1;
        mw[0] = 1'b0;

        // Load it back
        access(0, 1'b1, 1'b0, 32'd1032, 32'd0, dc);
        chk("ld_cycle", 0, dc, 32'd5);
        chk("ld_data", 0, rdat[0], 32'hDEADBEEF);

        // WAIT_CYCLES=0 loads, including an unaligned alias
        access(1, 1'b1, 1'b0, 32'd1024, 32'd0, dc);
        chk("w0_cycle", 1, dc, 32'd3);
        chk("w0_data", 1, rdat[1], 32'h12345678);
        access(1, 1'b1, 1'b0, 32'd1027, 32'd0, dc);
        chk("w0_alias", 1, rdat[1], 32'h12345678);

        // Read+write together is a write; back-to-back with the following load
        access(0, 1'b1, 1'b1, 32'd1028, 32'h0000CAFE, dc);
        chk("rw_cycle", 0, dc, 32'd5);
        chk("rw_rdata_kept", 0, rdat[0], 32'hDEADBEEF);
        chk("rw_mem_lo", 0, {16'd0, mem0[2]}, 32'h0000CAFE);
        chk("rw_mem_hi", 0, {16'd0, mem0[3]}, 32'h00000000);
        access(0, 1'b1, 1'b0, 32'd1028, 32'd0, dc);
        chk("rw_readback", 0, rdat[0], 32'h0000CAFE);
        access(1, 1'b0, 1'b1, 32'd1032, 32'hA5A55A5A, dc);
        chk("w0_wr_cycle", 1, dc, 32'd3);
        access(1, 1'b1, 1'b0, 32'd1032, 32'd0, dc);
        chk("w0_wr_back", 1, rdat[1], 32'hA5A55A5A);

        // Reset in the middle of WR_HI
        mw[0] = 1'b1; ad[0] = 32'd1040; wd[0] = 32'h11112222;
        repeat (4) @(negedge clk);
        chk("pre_rst_we_n", 0, {31'd0, we_n[0]}, 32'd0);
        chk("pre_rst_addr", 0, {14'd0, sa[0]}, 32'd9);
        #1;
        rst = 1'b0; mw[0] = 1'b0;
        #1;
        chk("arst_we_n", 0, {31'd0, we_n[0]}, 32'd1);
        chk("arst_oe", 0, {31'd0, oe[0]}, 32'd0);
        chk("arst_ready", 0, {31'd0, rdy[0]}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 0, {31'd0, rdy[0]}, 32'd1);
        chk("post_rst_rdata", 0, rdat[0], 32'd0);
        chk("post_rst_addr", 0, {14'd0, sa[0]}, 32'd0);

        // A fresh access after reset still completes normally
        @(posedge clk); #1;
        access(0, 1'b1, 1'b0, 32'd1032, 32'd0, dc);
        chk("post_rst_ld", 0, rdat[0], 32'hDEADBEEF);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
